// File: rtl/fsm_1_rx_decoder.sv
// rtl/fsm_1_rx_decoder.sv - receive-side decoder for the 4-bit {F,0,1,1} serial frame
//
// Purpose: aligns to the serial frame stream, recovers the flag bit F, checks
// the three framing bits, counts bad frames and keeps lock with hysteresis.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   sm_in        in   serial frame stream, one bit per clock, oldest first
//   frame_valid  out  one-cycle pulse, good frame decoded while locked
//   flag_out     out  recovered F, updated with frame_valid, held otherwise
//   frame_err    out  one-cycle pulse, checked frame had a framing mismatch
//   locked       out  alignment locked
//   err_count    out  saturating count of bad frames
module fsm_1_rx_decoder #(
  parameter int CNT_W       = 8,
  parameter int LOCK_FRAMES = 2,
  parameter int UNLOCK_ERRS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sm_in,
  output logic             frame_valid,
  output logic             flag_out,
  output logic             frame_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_FB   = 3'd1,
    S_C0   = 3'd2,
    S_C1   = 3'd3,
    S_C2   = 3'd4
  } state_e;

  localparam logic [4:0]       LOCK_N   = 5'(LOCK_FRAMES);
  localparam logic [4:0]       UNLOCK_N = 5'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       hist_q, hist_d;
  logic             flag_cap_q, flag_cap_d;
  logic             bad_q, bad_d;
  logic [3:0]       good_run_q, good_run_d;
  logic [3:0]       bad_run_q, bad_run_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             flag_out_q, flag_out_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Frame-end evaluation folds in the last bit, which is still on sm_in.
  logic       bad_f;
  logic [4:0] good_inc;
  logic [4:0] bad_inc;
  logic       lock_hit;
  logic       unlock_hit;

  assign bad_f      = bad_q | ~sm_in;
  assign good_inc   = {1'b0, good_run_q} + 5'd1;
  assign bad_inc    = {1'b0, bad_run_q} + 5'd1;
  assign lock_hit   = (good_inc >= LOCK_N);
  assign unlock_hit = (bad_inc >= UNLOCK_N);

  // State register (holds every registered signal of the block)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HUNT;
      hist_q        <= 2'b11;
      flag_cap_q    <= 1'b0;
      bad_q         <= 1'b0;
      good_run_q    <= 4'd0;
      bad_run_q     <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      flag_out_q    <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      flag_cap_q    <= flag_cap_d;
      bad_q         <= bad_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      flag_out_q    <= flag_out_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // 011 appears at only one phase of a clean {F,0,1,1} stream: it ends on C2,
      // so the following bit is F.
      S_HUNT: if ({hist_q, sm_in} == 3'b011) state_d = S_FB;
      S_FB:   state_d = S_C0;
      S_C0:   state_d = S_C1;
      S_C1:   state_d = S_C2;
      S_C2: begin
        if (!bad_f)                      state_d = S_FB;
        else if (!locked_q || unlock_hit) state_d = S_HUNT;
        else                             state_d = S_FB;  // flywheel through one bad frame
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    hist_d        = hist_q;
    flag_cap_d    = flag_cap_q;
    bad_d         = bad_q;
    good_run_d    = good_run_q;
    bad_run_d     = bad_run_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    flag_out_d    = flag_out_q;
    locked_d      = locked_q;
    err_count_d   = err_count_q;
    case (state_q)
      S_HUNT: hist_d = {hist_q[0], sm_in};
      S_FB: begin
        flag_cap_d = sm_in;
        bad_d      = 1'b0;
      end
      S_C0: bad_d = sm_in;
      S_C1: bad_d = bad_q | ~sm_in;
      S_C2: begin
        if (!bad_f) begin
          good_run_d = lock_hit ? LOCK_N[3:0] : good_inc[3:0];
          bad_run_d  = 4'd0;
          if (locked_q || lock_hit) begin
            locked_d      = 1'b1;
            frame_valid_d = 1'b1;
            flag_out_d    = flag_cap_q;
          end
        end else begin
          frame_err_d = 1'b1;
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
          good_run_d = 4'd0;
          if (!locked_q || unlock_hit) begin
            locked_d  = 1'b0;
            bad_run_d = 4'd0;
            hist_d    = 2'b11;
          end else begin
            bad_run_d = bad_inc[3:0];
          end
        end
      end
      default: hist_d = 2'b11;
    endcase
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign flag_out    = flag_out_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

endmodule
